// File: rtl/cordic_hyp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_hyp_pkg
//  Description : Shared constants for the hyperbolic CORDIC unit: the
//                atanh(2^-i) table, gain and ln2 constants (all Q16.16),
//                function-select codes, FSM state encoding and the
//                repeat-index rule of the hyperbolic iteration sequence.
//  Optional    : CORDIC_HYP_SQRT_EN (consumed by cordic_hyp_unit)
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_hyp_pkg;

    // Fixed-point constants, Q16.16
    localparam logic signed [31:0] c_INV_KH  = 32'sd79134;   // 1/K_h incl. repeats
    localparam logic signed [31:0] c_LN2     = 32'sd45426;   // ln(2)
    localparam logic signed [31:0] c_INV_LN2 = 32'sd94548;   // 1/ln(2)
    localparam logic signed [31:0] c_ONE     = 32'sd65536;   // 1.0
    localparam logic signed [31:0] c_QUARTER = 32'sd16384;   // 0.25

    // Function select
    localparam logic [1:0] c_MODE_EXP  = 2'd0;
    localparam logic [1:0] c_MODE_LN   = 2'd1;
    localparam logic [1:0] c_MODE_SQRT = 2'd2;
    localparam logic [1:0] c_MODE_RSVD = 2'd3;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_ITER   = 3'd2,
        ST_POST   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Hyperbolic CORDIC only converges if indices 4, 13, 40, ... (k -> 3k+1)
    // are executed twice.
    function automatic logic is_repeat_idx(input logic [5:0] idx);
        return (idx == 6'd4) || (idx == 6'd13) || (idx == 6'd40);
    endfunction

    // atanh(2^-i) in Q16.16, i = 1..30
    function automatic logic [31:0] atanh_lut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd1:    v = 32'd35999;
            5'd2:    v = 32'd16739;
            5'd3:    v = 32'd8235;
            5'd4:    v = 32'd4107;
            5'd5:    v = 32'd2049;
            5'd6:    v = 32'd1024;
            5'd7:    v = 32'd512;
            5'd8:    v = 32'd256;
            5'd9:    v = 32'd128;
            5'd10:   v = 32'd64;
            5'd11:   v = 32'd32;
            5'd12:   v = 32'd16;
            5'd13:   v = 32'd8;
            5'd14:   v = 32'd4;
            5'd15:   v = 32'd2;
            5'd16:   v = 32'd1;
            5'd17:   v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_hyp_core.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_hyp_core
//  Description : X/Y/Z shift-add engine of the hyperbolic CORDIC. Loads the
//                initial vector, then performs one micro-rotation per cycle
//                over i = 1..ITERATIONS, repeating indices 4/13/40.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - load X/Y/Z and restart the sequence
//                i_vectoring     - 1: drive Y to 0, 0: drive Z to 0
//                i_freeze        - sequence runs but X/Y/Z hold
//                i_x0/i_y0/i_z0  - initial vector, Q(W-16).16
//                o_x/o_y/o_z     - current vector
//                o_last          - high during the final micro-step
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_hyp_core #(
    parameter int W          = 32,
    parameter int ITERATIONS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_vectoring,
    input  logic                i_freeze,
    input  logic signed [W-1:0] i_x0,
    input  logic signed [W-1:0] i_y0,
    input  logic signed [W-1:0] i_z0,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic signed [W-1:0] o_z,
    output logic                o_last
);
    import cordic_hyp_pkg::*;

    logic signed [W-1:0] r_x, r_y, r_z;
    logic [4:0]          r_idx;
    logic                r_rep;     // current index already executed once
    logic                r_busy;
    logic                r_vec;

    logic                w_is_rep;
    logic                w_final;
    logic                w_dpos;
    logic signed [W-1:0] w_xs, w_ys, w_at;

    assign w_is_rep = is_repeat_idx({1'b0, r_idx});
    assign w_final  = (r_idx == 5'(ITERATIONS)) && (!w_is_rep || r_rep);

    // Rotation drives Z toward 0 (d = sign Z); vectoring drives Y toward 0
    // (d = -sign Y). Zero counts as positive.
    assign w_dpos = r_vec ? r_y[W-1] : ~r_z[W-1];

    assign w_xs = r_x >>> r_idx;
    assign w_ys = r_y >>> r_idx;
    assign w_at = W'($signed(atanh_lut(r_idx)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_idx  <= 5'd1;
            r_rep  <= 1'b0;
            r_busy <= 1'b0;
            r_vec  <= 1'b0;
        end else if (i_load) begin
            r_x    <= i_x0;
            r_y    <= i_y0;
            r_z    <= i_z0;
            r_vec  <= i_vectoring;
            r_idx  <= 5'd1;
            r_rep  <= 1'b0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (!i_freeze) begin
                if (w_dpos) begin
                    r_x <= r_x + w_ys;
                    r_y <= r_y + w_xs;
                    r_z <= r_z - w_at;
                end else begin
                    r_x <= r_x - w_ys;
                    r_y <= r_y - w_xs;
                    r_z <= r_z + w_at;
                end
            end
            if (w_final) begin
                r_busy <= 1'b0;
            end else if (w_is_rep && !r_rep) begin
                r_rep <= 1'b1;
            end else begin
                r_rep <= 1'b0;
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_z    = r_z;
    assign o_last = r_busy && w_final;

endmodule
`default_nettype wire

// File: rtl/cordic_hyp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_hyp_unit
//  Description : Iterative hyperbolic CORDIC computing exp(x) or ln(x)
//                (optionally sqrt(x)) on a signed fixed-point operand, with
//                range reduction, rounding, saturation and domain errors.
//                Fixed latency of ITERATIONS + repeats + 2 cycles.
//  Optional    : CORDIC_HYP_SQRT_EN - enables mode 2 = sqrt(x)
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                i_val/i_mode      - operand (Q.F_IN) and function select
//                i_valid/o_ready   - input handshake
//                o_result          - result (Q.F_OUT)
//                o_err/o_sat       - domain/mode error, saturation
//                o_valid/i_ready   - output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_hyp_unit #(
    parameter int N          = 12,
    parameter int F_IN       = 8,
    parameter int M          = 24,
    parameter int F_OUT      = 8,
    parameter int W          = 32,
    parameter int ITERATIONS = 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] i_val,
    input  logic [1:0]   i_mode,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [M-1:0] o_result,
    output logic         o_err,
    output logic         o_sat,
    output logic         o_valid,
    input  logic         i_ready
);
    import cordic_hyp_pkg::*;

    localparam logic signed [63:0] c_HALF = 64'sd1 <<< (15 - F_OUT);
    localparam int                 c_RSH  = 16 - F_OUT;
    localparam logic signed [63:0] c_MAX  = (64'sd1 <<< (M - 1)) - 64'sd1;
    localparam logic signed [63:0] c_MIN  = -(64'sd1 <<< (M - 1));

    state_t              r_state;
    logic [N-1:0]        r_val;
    logic [1:0]          r_mode;
    logic                r_err;
    logic                r_zero;     // exact-zero result, no iteration needed
    logic signed [7:0]   r_k;        // range-reduction exponent

    logic signed [W-1:0] w_cx, w_cy, w_cz;
    logic                w_core_last;
    logic                w_core_load;

    // ------------------------------------------------------------------
    // Range reduction (evaluated while in REDUCE)
    // ------------------------------------------------------------------
    logic signed [63:0]  w_x64;      // operand in Q.16
    logic signed [63:0]  w_kprod;    // x / ln2 in Q.32
    logic signed [63:0]  w_kexp64;
    logic signed [7:0]   w_kexp;
    logic signed [63:0]  w_r64;      // exp residual, |r| <= ln2/2
    logic [4:0]          w_msb;
    logic [63:0]         w_m64;      // mantissa in [0.5,1), Q.16
    logic signed [7:0]   w_kln;

    assign w_x64    = 64'($signed(r_val)) <<< (16 - F_IN);
    assign w_kprod  = w_x64 * 64'(c_INV_LN2);
    assign w_kexp64 = (w_kprod + 64'sd2147483648) >>> 32;
    assign w_kexp   = w_kexp64[7:0];
    assign w_r64    = w_x64 - 64'(w_kexp) * 64'(c_LN2);

    always_comb begin
        w_msb = '0;
        for (int b = 0; b < N; b++) begin
            if (r_val[b]) w_msb = 5'(b);
        end
    end

    // x = raw * 2^-F_IN = m * 2^(msb+1-F_IN), m = raw * 2^-(msb+1)
    assign w_m64 = (64'(r_val) << 15) >> w_msb;
    assign w_kln = 8'(int'(w_msb) + 1 - F_IN);

    logic signed [W-1:0] w_init_x, w_init_y, w_init_z;
    logic                w_init_vec;
    logic                w_red_err;
    logic                w_red_zero;
    logic signed [7:0]   w_red_k;

    always_comb begin
        w_init_x   = '0;
        w_init_y   = '0;
        w_init_z   = '0;
        w_init_vec = 1'b0;
        w_red_err  = 1'b0;
        w_red_zero = 1'b0;
        w_red_k    = '0;
        case (r_mode)
            c_MODE_EXP: begin
                w_init_x = W'(c_INV_KH);
                w_init_z = w_r64[W-1:0];
                w_red_k  = w_kexp;
            end
            c_MODE_LN: begin
                if (r_val[N-1] || (r_val == '0)) begin
                    w_red_err = 1'b1;
                end else begin
                    // atanh((m-1)/(m+1)) = ln(m)/2
                    w_init_x   = $signed(w_m64[W-1:0]) + W'(c_ONE);
                    w_init_y   = $signed(w_m64[W-1:0]) - W'(c_ONE);
                    w_init_vec = 1'b1;
                    w_red_k    = w_kln;
                end
            end
`ifdef CORDIC_HYP_SQRT_EN
            c_MODE_SQRT: begin
                if (r_val[N-1]) begin
                    w_red_err = 1'b1;
                end else if (r_val == '0) begin
                    w_red_zero = 1'b1;
                end else begin
                    // Even exponent so that 2^(k/2) is a plain shift; the
                    // mantissa then lies in [0.25,1).
                    w_init_vec = 1'b1;
                    if (w_kln[0]) begin
                        w_init_x = $signed(W'(w_m64 >> 1)) + W'(c_QUARTER);
                        w_init_y = $signed(W'(w_m64 >> 1)) - W'(c_QUARTER);
                        w_red_k  = w_kln + 8'sd1;
                    end else begin
                        w_init_x = $signed(w_m64[W-1:0]) + W'(c_QUARTER);
                        w_init_y = $signed(w_m64[W-1:0]) - W'(c_QUARTER);
                        w_red_k  = w_kln;
                    end
                end
            end
`else
            c_MODE_SQRT: begin
                w_red_err = 1'b1;
            end
`endif
            c_MODE_RSVD: begin
                w_red_err = 1'b1;
            end
            default: begin
                w_red_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CORDIC engine
    // ------------------------------------------------------------------
    assign w_core_load = (r_state == ST_REDUCE);

    cordic_hyp_core #(
        .W          (W),
        .ITERATIONS (ITERATIONS)
    ) u_core (
        .clk         (CLK),
        .rst         (RST),
        .i_load      (w_core_load),
        .i_vectoring (w_init_vec),
        .i_freeze    (r_err | r_zero),
        .i_x0        (w_init_x),
        .i_y0        (w_init_y),
        .i_z0        (w_init_z),
        .o_x         (w_cx),
        .o_y         (w_cy),
        .o_z         (w_cz),
        .o_last      (w_core_last)
    );

    // ------------------------------------------------------------------
    // Post-processing: undo range reduction, round, saturate
    // ------------------------------------------------------------------
    logic signed [63:0] w_post;
    logic signed [63:0] w_sum;
    logic signed [7:0]  w_sh_k;
    logic [6:0]         w_sh;
    logic signed [63:0] w_rnd;
    logic               w_hi, w_lo;
    logic [M-1:0]       w_res;

    always_comb begin
        w_post = '0;
        w_sum  = '0;
        w_sh_k = '0;
        w_sh   = '0;
        case (r_mode)
            c_MODE_EXP: begin
                // cosh(r) + sinh(r) = e^r, then scale by 2^k
                w_sum  = 64'(w_cx) + 64'(w_cy);
                w_sh_k = r_k;
            end
            c_MODE_LN: begin
                w_post = (64'(w_cz) <<< 1) + 64'(r_k) * 64'(c_LN2);
            end
`ifdef CORDIC_HYP_SQRT_EN
            c_MODE_SQRT: begin
                w_sum  = (64'(w_cx) * 64'(c_INV_KH)) >>> 16;
                w_sh_k = r_k >>> 1;
            end
`endif
            default: begin
                w_post = '0;
            end
        endcase
        if ((r_mode == c_MODE_EXP) || (r_mode == c_MODE_SQRT)) begin
            if (w_sh_k[7]) begin
                w_sh   = 7'(-w_sh_k);
                w_post = w_sum >>> w_sh;
            end else begin
                w_sh   = w_sh_k[6:0];
                w_post = w_sum <<< w_sh;
            end
        end
        if (r_err || r_zero) begin
            w_post = '0;
        end
    end

    assign w_rnd = (w_post + c_HALF) >>> c_RSH;
    assign w_hi  = (w_rnd > c_MAX);
    assign w_lo  = (w_rnd < c_MIN);
    assign w_res = w_hi ? c_MAX[M-1:0] : (w_lo ? c_MIN[M-1:0] : w_rnd[M-1:0]);

    // ------------------------------------------------------------------
    // Sequencer and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_val    <= '0;
            r_mode   <= '0;
            r_err    <= 1'b0;
            r_zero   <= 1'b0;
            r_k      <= '0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_err    <= 1'b0;
            o_sat    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_val   <= i_val;
                        r_mode  <= i_mode;
                        o_ready <= 1'b0;
                        r_state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    // Errors still pass through ITER (core frozen) so the
                    // latency does not depend on the operand.
                    r_err   <= w_red_err;
                    r_zero  <= w_red_zero;
                    r_k     <= w_red_k;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    if (w_core_last) begin
                        r_state <= ST_POST;
                    end
                end
                ST_POST: begin
                    o_result <= w_res;
                    o_err    <= r_err;
                    o_sat    <= w_hi | w_lo;
                    o_valid  <= 1'b1;
                    r_state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{w_kexp64[63:8], w_r64[63:W], w_m64[63:W]};

endmodule
`default_nettype wire
